lsu_ctrl: RTL and testbench

- Multi-cycle load/store sequencer between the MEM stage and the data bus.
- Consumes the decoder's mem_read/mem_write/load_type/store_type controls.
- Issues one valid/ready bus transaction per access, stalls the pipeline meanwhile, and returns aligned, sign-/zero-extended load data.
- Detects misaligned accesses and bus timeouts without touching the bus.

---
 rtl/lsu_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: turns one MEM-stage access into a single valid/ready bus
// transaction, stalling the pipeline until the extended result is ready.
module lsu_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  load_type,
  input  logic [2:0]  store_type,
  input  logic [63:0] mem_addr,
  input  logic [63:0] mem_wdata,
  output logic        lsu_stall,
  output logic        lsu_done,
  output logic [63:0] lsu_rdata,
  output logic        lsu_misalign,
  output logic        lsu_buserr,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic        bus_req_write,
  output logic [63:0] bus_req_addr,
  output logic [63:0] bus_req_wdata,
  output logic [7:0]  bus_req_wstrb,
  input  logic        bus_resp_valid,
  input  logic [63:0] bus_resp_rdata,
  input  logic        bus_resp_err
);

  // Handshake: a request transfers on the cycle bus_req_valid & bus_req_ready are
  // both high; fields hold steady until then. bus_resp_valid is a one-cycle pulse.
  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_e;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);

  state_e      state_q, state_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [7:0]  wstrb_q, wstrb_d;
  logic        write_q, write_d;
  logic [2:0]  ltype_q, ltype_d;
  logic [15:0] cnt_q, cnt_d;
  logic [63:0] rdata_q, rdata_d;
  logic        misalign_q, misalign_d;
  logic        buserr_q, buserr_d;

  logic        go;
  logic [1:0]  size_l2;
  logic        misaligned;
  logic [7:0]  size_mask;
  logic [63:0] ld_shift;
  logic [63:0] ld_ext;

  assign go = mem_valid & (mem_read | mem_write);

  // A write wins when both read and write are set.
  always_comb begin
    size_l2 = 2'd0;
    if (mem_write) begin
      case (store_type)
        3'b101:  size_l2 = 2'd1;
        3'b110:  size_l2 = 2'd2;
        3'b111:  size_l2 = 2'd3;
        default: size_l2 = 2'd0;
      endcase
    end else begin
      case (load_type)
        3'b010, 3'b110: size_l2 = 2'd1;
        3'b011, 3'b111: size_l2 = 2'd2;
        3'b100:         size_l2 = 2'd3;
        default:        size_l2 = 2'd0;
      endcase
    end
  end

  always_comb begin
    misaligned = 1'b0;
    size_mask  = 8'h01;
    case (size_l2)
      2'd1: begin misaligned = mem_addr[0];        size_mask = 8'h03; end
      2'd2: begin misaligned = |mem_addr[1:0];     size_mask = 8'h0F; end
      2'd3: begin misaligned = |mem_addr[2:0];     size_mask = 8'hFF; end
      default: begin misaligned = 1'b0;            size_mask = 8'h01; end
    endcase
  end

  assign ld_shift = bus_resp_rdata >> {addr_q[2:0], 3'b000};

  always_comb begin
    ld_ext = 64'd0;
    case (ltype_q)
      3'b001:  ld_ext = {{56{ld_shift[7]}}, ld_shift[7:0]};
      3'b010:  ld_ext = {{48{ld_shift[15]}}, ld_shift[15:0]};
      3'b011:  ld_ext = {{32{ld_shift[31]}}, ld_shift[31:0]};
      3'b100:  ld_ext = ld_shift;
      3'b101:  ld_ext = {56'd0, ld_shift[7:0]};
      3'b110:  ld_ext = {48'd0, ld_shift[15:0]};
      3'b111:  ld_ext = {32'd0, ld_shift[31:0]};
      default: ld_ext = 64'd0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    write_d    = write_q;
    ltype_d    = ltype_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    misalign_d = misalign_q;
    buserr_d   = buserr_q;
    case (state_q)
      IDLE: begin
        if (go) begin
          rdata_d    = 64'd0;
          buserr_d   = 1'b0;
          misalign_d = misaligned;
          if (misaligned) begin
            state_d = DONE;
          end else begin
            state_d = REQ;
            addr_d  = mem_addr;
            wdata_d = mem_wdata << {mem_addr[2:0], 3'b000};
            wstrb_d = mem_write ? (size_mask << mem_addr[2:0]) : 8'h00;
            write_d = mem_write;
            ltype_d = load_type;
          end
        end
      end
      REQ: begin
        if (bus_req_ready) begin
          state_d = RESP;
          cnt_d   = 16'd0;
        end
      end
      RESP: begin
        // A response on the timeout cycle still wins over the timeout.
        if (bus_resp_valid) begin
          state_d  = DONE;
          buserr_d = bus_resp_err;
          rdata_d  = (write_q || bus_resp_err) ? 64'd0 : ld_ext;
        end else if (cnt_q == TMO_LAST) begin
          state_d  = DONE;
          buserr_d = 1'b1;
          rdata_d  = 64'd0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= 64'd0;
      wdata_q    <= 64'd0;
      wstrb_q    <= 8'd0;
      write_q    <= 1'b0;
      ltype_q    <= 3'd0;
      cnt_q      <= 16'd0;
      rdata_q    <= 64'd0;
      misalign_q <= 1'b0;
      buserr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      write_q    <= write_d;
      ltype_q    <= ltype_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      misalign_q <= misalign_d;
      buserr_q   <= buserr_d;
    end
  end

  // Stall drops in DONE so the pipeline advances on the lsu_done cycle.
  assign lsu_stall     = ((state_q == IDLE) & go) | (state_q == REQ) | (state_q == RESP);
  assign lsu_done      = (state_q == DONE);
  assign lsu_rdata     = (state_q == DONE) ? rdata_q : 64'd0;
  assign lsu_misalign  = (state_q == DONE) & misalign_q;
  assign lsu_buserr    = (state_q == DONE) & buserr_q;
  assign bus_req_valid = (state_q == REQ);
  assign bus_req_write = (state_q == REQ) & write_q;
  assign bus_req_addr  = (state_q == REQ) ? {addr_q[63:3], 3'b000} : 64'd0;
  assign bus_req_wdata = (state_q == REQ) ? wdata_q : 64'd0;
  assign bus_req_wstrb = (state_q == REQ) ? wstrb_q : 8'd0;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: directed scenarios plus random accesses checked against a
// byte-level model of the load/store rules.
module tb_lsu_ctrl;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid, mem_read, mem_write;
  logic [2:0]  load_type, store_type;
  logic [63:0] mem_addr, mem_wdata;
  logic        lsu_stall, lsu_done, lsu_misalign, lsu_buserr;
  logic [63:0] lsu_rdata;
  logic        bus_req_valid, bus_req_ready, bus_req_write;
  logic [63:0] bus_req_addr, bus_req_wdata;
  logic [7:0]  bus_req_wstrb;
  logic        bus_resp_valid, bus_resp_err;
  logic [63:0] bus_resp_rdata;

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] exp_q[$];

  lsu_ctrl #(.TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_read(mem_read), .mem_write(mem_write),
    .load_type(load_type), .store_type(store_type),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .lsu_stall(lsu_stall), .lsu_done(lsu_done), .lsu_rdata(lsu_rdata),
    .lsu_misalign(lsu_misalign), .lsu_buserr(lsu_buserr),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
    .bus_req_write(bus_req_write), .bus_req_addr(bus_req_addr),
    .bus_req_wdata(bus_req_wdata), .bus_req_wstrb(bus_req_wstrb),
    .bus_resp_valid(bus_resp_valid), .bus_resp_rdata(bus_resp_rdata),
    .bus_resp_err(bus_resp_err)
  );

  always #5 clk = ~clk;

  // ---------------- clock / drive helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    mem_valid = 0; mem_read = 0; mem_write = 0;
    load_type = 0; store_type = 0; mem_addr = 0; mem_wdata = 0;
    bus_req_ready = 0; bus_resp_valid = 0; bus_resp_rdata = 0; bus_resp_err = 0;
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  // ---------------- reference model ----------------
  function automatic int size_of(bit wr, logic [2:0] t);
    if (wr) begin
      case (t)
        3'b101: return 2;
        3'b110: return 4;
        3'b111: return 8;
        default: return 1;
      endcase
    end
    case (t)
      3'b010, 3'b110: return 2;
      3'b011, 3'b111: return 4;
      3'b100: return 8;
      default: return 1;
    endcase
  endfunction

  function automatic logic [63:0] model_load(logic [2:0] t, logic [63:0] addr, logic [63:0] rd);
    int sz;
    int off;
    logic [63:0] v;
    sz = size_of(1'b0, t);
    off = int'(addr[2:0]);
    v = 64'd0;
    for (int i = 0; i < sz; i++)
      if (off + i < 8) v[8*i +: 8] = rd[8*(off+i) +: 8];
    if ((t == 3'b001 || t == 3'b010 || t == 3'b011) && v[8*sz-1])
      for (int i = 8*sz; i < 64; i++) v[i] = 1'b1;
    return v;
  endfunction

  // ---------------- one full access, walked cycle by cycle ----------------
  task automatic run_access(input bit wr, input logic [2:0] typ, input logic [63:0] addr,
                            input logic [63:0] wdata, input int rdly, input int rsp_d,
                            input bit no_rsp, input logic [63:0] rdata, input bit err,
                            input bit both);
    int sz, off, nresp;
    bit mis, tmo;
    logic [7:0]  e_wstrb;
    logic [63:0] e_addr, e_wdata, e_rdata, got;
    bit e_berr;
    sz  = size_of(wr, typ);
    off = int'(addr[2:0]);
    mis = (int'(addr % 64'(sz)) != 0);
    e_wstrb = 8'h00;
    if (wr) for (int b = 0; b < 8; b++) if (b >= off && b < off + sz) e_wstrb[b] = 1'b1;
    e_addr  = addr - 64'(off);
    e_wdata = wdata << (8 * off);
    tmo     = no_rsp || (rsp_d > TMO - 1);
    e_berr  = !mis && (tmo || err);
    e_rdata = (mis || wr || tmo || err) ? 64'd0 : model_load(typ, addr, rdata);
    exp_q.push_back(e_rdata);

    // go cycle (IDLE)
    tick();
    mem_valid = 1; mem_read = !wr || both; mem_write = wr;
    load_type = wr ? (both ? 3'b011 : 3'b000) : typ;
    store_type = wr ? typ : 3'b000;
    mem_addr = addr; mem_wdata = wdata;
    bus_req_ready = 0; bus_resp_valid = 0;
    @(negedge clk);
    n_cmp++;
    if (lsu_stall !== 1'b1 || lsu_done !== 1'b0 || bus_req_valid !== 1'b0) begin
      n_err++;
      $display("FAIL go_cycle: stall=%b done=%b req_valid=%b, want stall=1 done=0 req_valid=0",
               lsu_stall, lsu_done, bus_req_valid);
    end

    if (!mis) begin
      for (int k = 0; k <= rdly; k++) begin
        tick();
        mem_valid = 0; mem_addr = rand64(); mem_wdata = rand64(); load_type = 3'($urandom);
        bus_req_ready = (k == rdly);
        @(negedge clk);
        n_cmp++;
        if (bus_req_valid !== 1'b1 || bus_req_write !== wr || bus_req_addr !== e_addr ||
            (wr && bus_req_wdata !== e_wdata) || bus_req_wstrb !== e_wstrb ||
            lsu_stall !== 1'b1 || lsu_done !== 1'b0) begin
          n_err++;
          $display("FAIL req_fields: v=%b w=%b a=%h d=%h s=%h stall=%b done=%b, want v=1 w=%b a=%h d=%h s=%h stall=1 done=0",
                   bus_req_valid, bus_req_write, bus_req_addr, bus_req_wdata, bus_req_wstrb,
                   lsu_stall, lsu_done, wr, e_addr, e_wdata, e_wstrb);
        end
      end
      nresp = tmo ? TMO : rsp_d + 1;
      for (int k = 0; k < nresp; k++) begin
        tick();
        bus_req_ready = 0;
        bus_resp_valid = (!no_rsp && k == rsp_d);
        bus_resp_rdata = bus_resp_valid ? rdata : rand64();
        bus_resp_err = bus_resp_valid ? err : 1'($urandom);
        @(negedge clk);
        n_cmp++;
        if (lsu_stall !== 1'b1 || lsu_done !== 1'b0 || bus_req_valid !== 1'b0) begin
          n_err++;
          $display("FAIL resp_wait: stall=%b done=%b req_valid=%b at resp cycle %0d, want 1/0/0",
                   lsu_stall, lsu_done, bus_req_valid, k);
        end
      end
    end

    // DONE cycle; a go offered now must be ignored
    tick();
    bus_resp_valid = 0; bus_resp_err = 0; bus_req_ready = 0;
    mem_valid = 1'($urandom); mem_read = 1'($urandom); mem_write = 1'($urandom);
    mem_addr = rand64(); load_type = 3'($urandom); store_type = 3'($urandom);
    @(negedge clk);
    got = exp_q.pop_front();
    n_cmp++;
    if (lsu_done !== 1'b1 || lsu_misalign !== mis || lsu_buserr !== e_berr ||
        lsu_rdata !== got || lsu_stall !== 1'b0 || bus_req_valid !== 1'b0) begin
      n_err++;
      $display("FAIL done_cycle: done=%b mis=%b berr=%b rdata=%h stall=%b rv=%b, want done=1 mis=%b berr=%b rdata=%h stall=0 rv=0",
               lsu_done, lsu_misalign, lsu_buserr, lsu_rdata, lsu_stall, bus_req_valid,
               mis, e_berr, got);
    end
  endtask

  task automatic idle_check(input string name);
    tick();
    drive_idle();
    @(negedge clk);
    n_cmp++;
    if (lsu_done !== 1'b0 || lsu_stall !== 1'b0 || bus_req_valid !== 1'b0 || lsu_rdata !== 64'd0) begin
      n_err++;
      $display("FAIL %s: done=%b stall=%b rv=%b rdata=%h, want all 0", name,
               lsu_done, lsu_stall, bus_req_valid, lsu_rdata);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    drive_idle();
    rst = 1;
    repeat (2) tick();
    @(negedge clk);
    n_cmp++;
    if ({lsu_stall, lsu_done, lsu_misalign, lsu_buserr, bus_req_valid, bus_req_write} !== 6'd0 ||
        lsu_rdata !== 64'd0 || bus_req_addr !== 64'd0 || bus_req_wdata !== 64'd0 || bus_req_wstrb !== 8'd0) begin
      n_err++;
      $display("FAIL reset_outputs: stall=%b done=%b rdata=%h rv=%b addr=%h, want all 0",
               lsu_stall, lsu_done, lsu_rdata, bus_req_valid, bus_req_addr);
    end
    tick();
    rst = 0;
    @(negedge clk);
    idle_check("reset_idle");
  endtask

  task automatic test_lb_lbu();
    run_access(0, 3'b001, 64'h1003, 64'd0, 0, 0, 0, 64'h00000000_80FF0000, 0, 0);
    run_access(0, 3'b101, 64'h1003, 64'd0, 0, 0, 0, 64'h00000000_80FF0000, 0, 0);
    run_access(0, 3'b010, 64'h1006, 64'd0, 0, 0, 0, 64'h8001_0000_0000_0000, 0, 0);
    run_access(0, 3'b111, 64'h1004, 64'd0, 0, 1, 0, 64'hF234_5678_0000_0000, 0, 0);
    idle_check("after_loads");
  endtask

  task automatic test_store_stall();
    run_access(1, 3'b101, 64'h2006, 64'hABCD, 5, 0, 0, 64'd0, 0, 0);
    idle_check("after_sh");
  endtask

  task automatic test_misalign();
    run_access(0, 3'b011, 64'h3002, 64'd0, 0, 0, 0, 64'd0, 0, 0);
    run_access(1, 3'b111, 64'h3004, 64'h55, 0, 0, 0, 64'd0, 0, 0);
    run_access(0, 3'b110, 64'h3001, 64'd0, 0, 0, 0, 64'd0, 0, 0);
    idle_check("after_misalign");
  endtask

  task automatic test_timeout();
    run_access(0, 3'b100, 64'h5000, 64'd0, 0, 0, 1, 64'd0, 0, 0);
    run_access(0, 3'b100, 64'h5008, 64'd0, 0, 1, 0, rand64(), 1, 0);
    run_access(0, 3'b100, 64'h5010, 64'd0, 0, TMO - 1, 0, 64'h0123_4567_89AB_CDEF, 0, 0);
    idle_check("after_timeout");
  endtask

  task automatic test_reset_mid();
    tick();
    mem_valid = 1; mem_read = 1; mem_write = 0; load_type = 3'b100; mem_addr = 64'h4000;
    tick();
    mem_valid = 0; bus_req_ready = 1;
    tick();
    bus_req_ready = 0; rst = 1;
    tick();
    rst = 0;
    @(negedge clk);
    n_cmp++;
    if (lsu_done !== 1'b0 || lsu_stall !== 1'b0 || bus_req_valid !== 1'b0 || lsu_buserr !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid: done=%b stall=%b rv=%b berr=%b, want 0", lsu_done, lsu_stall,
               bus_req_valid, lsu_buserr);
    end
    tick();
    bus_resp_valid = 1; bus_resp_rdata = rand64(); bus_resp_err = 0;
    @(negedge clk);
    n_cmp++;
    if (lsu_done !== 1'b0 || lsu_rdata !== 64'd0 || lsu_stall !== 1'b0) begin
      n_err++;
      $display("FAIL late_resp: done=%b rdata=%h stall=%b, want 0", lsu_done, lsu_rdata, lsu_stall);
    end
    idle_check("late_resp_next");
    idle_check("late_resp_next2");
    run_access(0, 3'b011, 64'h4010, 64'd0, 1, 0, 0, rand64(), 0, 0);
    idle_check("after_recover");
  endtask

  task automatic test_rw_both();
    run_access(1, 3'b111, 64'h6000, rand64(), 0, 0, 0, rand64(), 0, 1);
    idle_check("after_both");
  endtask

  task automatic test_back_to_back();
    run_access(0, 3'b011, 64'h7000, 64'd0, 0, 0, 0, rand64(), 0, 0);
    run_access(1, 3'b100, 64'h7005, 64'h5A, 0, 0, 0, 64'd0, 0, 0);
    run_access(0, 3'b001, 64'h7007, 64'd0, 0, 0, 0, rand64(), 0, 0);
    run_access(1, 3'b110, 64'h700C, rand64(), 0, 0, 0, 64'd0, 0, 0);
    idle_check("after_b2b");
  endtask

  task automatic test_random();
    logic [2:0] ltypes[7];
    logic [2:0] stypes[4];
    ltypes = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111};
    stypes = '{3'b100, 3'b101, 3'b110, 3'b111};
    for (int n = 0; n < 40; n++) begin
      bit wr;
      logic [2:0] t;
      logic [63:0] a;
      int sz;
      wr = 1'($urandom);
      t  = wr ? stypes[$urandom_range(0, 3)] : ltypes[$urandom_range(0, 6)];
      sz = size_of(wr, t);
      a  = rand64();
      if ($urandom_range(0, 3) != 0) a = a - (a % 64'(sz));
      run_access(wr, t, a, rand64(), $urandom_range(0, 3), $urandom_range(0, 5),
                 ($urandom_range(0, 9) == 0), rand64(), ($urandom_range(0, 4) == 0), 0);
      if ($urandom_range(0, 1) == 1) idle_check("rand_gap");
    end
    idle_check("after_random");
  endtask

  initial begin
    test_reset();
    test_lb_lbu();
    test_store_stall();
    test_misalign();
    test_timeout();
    test_reset_mid();
    test_rw_both();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
